memory_arbiter: RTL and testbench
=================================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, 32, address width of all ports.
REQ-002 Parameter DATA_WIDTH, 32, data width of all ports.
REQ-003 Parameter MAX_DATA_BURST, 4, maximum consecutive data grants while fetch is waiting; legal range 1..15.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high; ports are named clock and reset.
REQ-005 clock  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 if_req / if_addr  input  1 / ADDR_WIDTH  instruction-fetch read request; held stable until if_gnt.
REQ-008 if_gnt / if_rvalid / if_rdata  output  1 / 1 / DATA_WIDTH  fetch grant pulse, response valid pulse, read data.
REQ-009 dm_req / dm_addr / dm_we / dm_wdata  input  1 / ADDR_WIDTH / 4 / DATA_WIDTH  data request; dm_we is a byte write mask, 0 = load.
REQ-010 dm_gnt / dm_rvalid / dm_rdata  output  1 / 1 / DATA_WIDTH  data grant pulse, response valid pulse, read data.
REQ-011 mem_req / mem_addr / mem_we / mem_wdata  output  1 / ADDR_WIDTH / 4 / DATA_WIDTH  request to the single shared memory port.
REQ-012 mem_gnt / mem_rvalid / mem_rdata  input  1 / 1 / DATA_WIDTH  memory accepts request; memory response (reads and writes) with data.
REQ-013 busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 FSM states SHALL be IDLE, REQ, RSP; at most one transaction outstanding.
REQ-015 IDLE: if any requester asserts req, the arbiter SHALL capture the winner's address, mask and wdata into registers, record the owner, pulse the winner's gnt for exactly that cycle, and go to REQ.
REQ-016 REQ: mem_req SHALL be 1 with mem_addr/mem_we/mem_wdata driven from the captured registers; on mem_gnt go to RSP.
REQ-017 RSP: on mem_rvalid, the owner's rvalid SHALL be 1 in the same cycle with rdata = mem_rdata (combinational route); go to IDLE.
REQ-018 Minimum transaction occupancy SHALL be 3 cycles (IDLE capture, REQ with mem_gnt, RSP with mem_rvalid); back-to-back captures every 3 cycles.
REQ-019 Priority: data wins over fetch, except when streak == MAX_DATA_BURST and if_req = 1, in which case fetch wins.
REQ-020 streak (4-bit) SHALL increment on a data grant given while if_req = 1, clear on any fetch grant, and clear on any IDLE cycle with if_req = 0.
REQ-021 The non-owner's rvalid SHALL stay 0; if_rdata/dm_rdata SHALL be 0 when their rvalid is 0.
REQ-022 mem_rvalid in IDLE or REQ and mem_gnt in IDLE or RSP SHALL be ignored (no rvalid forwarded, no state change).
REQ-023 A requester dropping req before grant SHALL simply lose arbitration; no partial capture.
REQ-024 mem_req SHALL be 0 outside REQ; mem_* data outputs hold last captured values.

Reset
REQ-025 On reset, state = IDLE, streak = 0, owner = fetch, captured registers = 0, all gnt/rvalid/mem_req/busy = 0.
REQ-026 Reset mid-transaction SHALL abandon it; a late mem_rvalid arriving after reset SHALL not be forwarded.

Structure
REQ-027 Shared package mem_arb_pkg SHALL hold the state enum (IDLE, REQ, RSP), owner enum (OWN_IF, OWN_DM), and byte-mask width constant 4.
REQ-028 Selection logic and streak counter SHALL live in one sub-module, mem_arb_select (inputs if_req, dm_req, capture strobe; output winner); FSM and capture registers stay in memory_arbiter.

Verification
REQ-029 Fetch only: if_req=1, if_addr=0x100, mem_gnt immediate, mem_rvalid with 0x00000013 next cycle -> if_gnt at cycle 0, mem_req at cycle 1 with addr 0x100, if_rvalid at cycle 2 with if_rdata 0x00000013.
REQ-030 Simultaneous: if_req and dm_req both 1, dm_addr 0x2000, dm_we 4'b1111 -> dm_gnt first, mem_we 4'b1111, dm_rvalid on response, if_rvalid 0.
REQ-031 Starvation: dm_req and if_req held 1, MAX_DATA_BURST=4 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-032 Slow memory: mem_gnt delayed 5 cycles, mem_rvalid delayed 3 -> mem_req held 5 cycles with stable addr, busy high throughout, no second gnt issued.
REQ-033 Reset in RSP, mem_rvalid one cycle after reset release -> no if_rvalid/dm_rvalid, state IDLE, busy 0.
REQ-034 Spurious mem_rvalid in IDLE with no requests -> all rvalid outputs remain 0, streak unchanged.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
//   state_t : arbiter FSM states (IDLE, REQ, RSP)
//   owner_t : which requester owns the outstanding transaction
package mem_arb_pkg;

  localparam int unsigned MASK_W   = 4;  // byte write-mask width
  localparam int unsigned STREAK_W = 4;  // consecutive data-grant counter width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arb_select.sv
// Fetch/data priority selection with anti-starvation streak counter.
// Data wins by default; once MAX_DATA_BURST data grants have been given
// while fetch was waiting, fetch wins the next arbitration.
//   clock, reset : clock and synchronous active-high reset
//   if_req       : fetch requester active
//   dm_req       : data requester active
//   idle         : arbiter FSM is in IDLE this cycle
//   capture      : a grant is being issued this cycle
//   winner       : requester that wins if a grant is issued
module mem_arb_select
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_DATA_BURST = 4
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   if_req,
  input  logic   dm_req,
  input  logic   idle,
  input  logic   capture,
  output owner_t winner
);

  logic [STREAK_W-1:0] streak;
  logic                at_limit;

  // Priority decision: fetch only wins when alone or when data has hit its burst limit.
  always_comb begin
    at_limit = (streak == STREAK_W'(MAX_DATA_BURST));
    winner   = OWN_DM;
    if (if_req && (!dm_req || at_limit)) begin
      winner = OWN_IF;
    end
  end

  // Streak counts data grants that made fetch wait; any relief for fetch clears it.
  always_ff @(posedge clock) begin
    if (reset) begin
      streak <= '0;
    end else if (capture) begin
      if (winner == OWN_IF || !if_req) begin
        streak <= '0;
      end else begin
        streak <= streak + STREAK_W'(1);
      end
    end else if (idle && !if_req) begin
      streak <= '0;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one shared
// memory port, one transaction outstanding at a time (IDLE -> REQ -> RSP).
//   clock, reset                              : clock, synchronous active-high reset
//   if_req/if_addr -> if_gnt/if_rvalid/if_rdata : fetch read port
//   dm_req/dm_addr/dm_we/dm_wdata -> dm_gnt/dm_rvalid/dm_rdata : data port
//   mem_req/mem_addr/mem_we/mem_wdata <- mem_gnt/mem_rvalid/mem_rdata : memory port
//   busy                                      : high whenever not IDLE
// Grants and response valids are combinational so a transaction can
// complete in three cycles.
module memory_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MAX_DATA_BURST = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  dm_req,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [MASK_W-1:0]     dm_we,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic                  dm_gnt,
  output logic                  dm_rvalid,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [MASK_W-1:0]     mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  state_t                state, state_nxt;
  owner_t                owner, winner;
  logic                  capture;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [MASK_W-1:0]     we_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  mem_arb_select #(
    .MAX_DATA_BURST(MAX_DATA_BURST)
  ) u_select (
    .clock  (clock),
    .reset  (reset),
    .if_req (if_req),
    .dm_req (dm_req),
    .idle   (state == IDLE),
    .capture(capture),
    .winner (winner)
  );

  // Next-state, grant pulses and response routing.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    if_gnt    = 1'b0;
    dm_gnt    = 1'b0;
    if_rvalid = 1'b0;
    dm_rvalid = 1'b0;
    if_rdata  = '0;
    dm_rdata  = '0;
    mem_req   = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (if_req || dm_req) begin
          capture   = 1'b1;
          if_gnt    = (winner == OWN_IF);
          dm_gnt    = (winner == OWN_DM);
          state_nxt = REQ;
        end
      end
      REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) begin
          state_nxt = RSP;
        end
      end
      RSP: begin
        if (mem_rvalid) begin
          if (owner == OWN_IF) begin
            if_rvalid = 1'b1;
            if_rdata  = mem_rdata;
          end else begin
            dm_rvalid = 1'b1;
            dm_rdata  = mem_rdata;
          end
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and capture of the winning request; fetch is always a read.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      owner   <= OWN_IF;
      addr_q  <= '0;
      we_q    <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        owner <= winner;
        if (winner == OWN_IF) begin
          addr_q  <= if_addr;
          we_q    <= '0;
          wdata_q <= '0;
        end else begin
          addr_q  <= dm_addr;
          we_q    <= dm_we;
          wdata_q <= dm_wdata;
        end
      end
    end
  end

  assign mem_addr  = addr_q;
  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomized bench for memory_arbiter against a transaction-level model,
// plus a few directed scenarios (fetch-only, starvation order, reset in RSP).
module tb_memory_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned MAXB = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          dm_req, dm_gnt, dm_rvalid;
  logic [AW-1:0] dm_addr;
  logic [3:0]    dm_we;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic          mem_req, mem_gnt, mem_rvalid, busy;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_we;
  logic [DW-1:0] mem_wdata, mem_rdata;

  memory_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_DATA_BURST(MAXB)
  ) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_addr(dm_addr), .dm_we(dm_we), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level model: whether a transaction is pending, whether the
  // memory has accepted it, who owns it, and how many data grants in a row
  // were given while fetch was kept waiting.
  bit            m_pending;
  bit            m_accepted;
  bit            m_fetch_owner;
  logic [AW-1:0] m_addr;
  logic [3:0]    m_we;
  logic [DW-1:0] m_wdata;
  int            m_data_run;
  bit            m_fetch_wins;
  bit            grant_log[$];

  task automatic model_reset();
    m_pending     = 0;
    m_accepted    = 0;
    m_fetch_owner = 1;
    m_addr        = '0;
    m_we          = '0;
    m_wdata       = '0;
    m_data_run    = 0;
  endtask

  // Let inputs settle and compare every output against the model.
  task automatic settle();
    bit            e_if_gnt, e_dm_gnt, e_if_rv, e_dm_rv;
    logic [DW-1:0] e_if_rd, e_dm_rd;
    #2;
    e_if_gnt = 0; e_dm_gnt = 0; e_if_rv = 0; e_dm_rv = 0;
    e_if_rd = '0; e_dm_rd = '0;
    m_fetch_wins = if_req && (!dm_req || m_data_run == int'(MAXB));
    if (!m_pending && (if_req || dm_req)) begin
      e_if_gnt = m_fetch_wins;
      e_dm_gnt = !m_fetch_wins;
    end
    if (m_pending && m_accepted && mem_rvalid) begin
      if (m_fetch_owner) begin e_if_rv = 1; e_if_rd = mem_rdata; end
      else               begin e_dm_rv = 1; e_dm_rd = mem_rdata; end
    end
    check("gnt",      64'({if_gnt, dm_gnt}),       64'({e_if_gnt, e_dm_gnt}));
    check("rvalid",   64'({if_rvalid, dm_rvalid}), 64'({e_if_rv, e_dm_rv}));
    check("if_rdata", 64'(if_rdata),               64'(e_if_rd));
    check("dm_rdata", 64'(dm_rdata),               64'(e_dm_rd));
    check("mem_req",  64'(mem_req),                64'(m_pending && !m_accepted));
    check("busy",     64'(busy),                   64'(m_pending));
    check("mem_addr", 64'(mem_addr),               64'(m_addr));
    check("mem_we_wdata", 64'({mem_we, mem_wdata}), 64'({m_we, m_wdata}));
    if (if_gnt || dm_gnt) grant_log.push_back(if_gnt);
  endtask

  // Clock edge: advance the model, then move to the next drive point.
  task automatic advance();
    @(posedge clock);
    if (reset) begin
      model_reset();
    end else if (!m_pending) begin
      if (if_req || dm_req) begin
        m_pending     = 1;
        m_accepted    = 0;
        m_fetch_owner = m_fetch_wins;
        m_addr        = m_fetch_wins ? if_addr : dm_addr;
        m_we          = m_fetch_wins ? 4'b0 : dm_we;
        m_wdata       = m_fetch_wins ? '0 : dm_wdata;
        if (m_fetch_wins || !if_req) m_data_run = 0;
        else                         m_data_run = m_data_run + 1;
      end else if (!if_req) begin
        m_data_run = 0;
      end
    end else if (!m_accepted) begin
      if (mem_gnt) m_accepted = 1;
    end else if (mem_rvalid) begin
      m_pending = 0;
    end
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    reset = 0; if_req = 0; if_addr = '0; dm_req = 0; dm_addr = '0;
    dm_we = '0; dm_wdata = '0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    settle();
    advance();
    reset = 0;
  endtask

  initial begin
    bit [9:0] order;
    idle_inputs();
    reset = 1;
    model_reset();
    @(posedge clock);
    @(negedge clock);

    // Reset state.
    settle();
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    advance();
    reset = 0;

    // Fetch-only transaction with immediate memory.
    if_req = 1; if_addr = 32'h100; mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'h13;
    settle();
    check("fo_if_gnt_c0", 64'(if_gnt), 64'(1));
    advance();
    if_req = 0;
    settle();
    check("fo_mem_req_c1", 64'({mem_req, mem_addr}), 64'({1'b1, 32'h100}));
    advance();
    settle();
    check("fo_if_rvalid_c2", 64'({if_rvalid, if_rdata}), 64'({1'b1, 32'h13}));
    advance();

    // Simultaneous requests: data wins and writes full mask.
    do_reset();
    if_req = 1; if_addr = 32'h40; dm_req = 1; dm_addr = 32'h2000; dm_we = 4'hF;
    dm_wdata = 32'hCAFE_F00D; mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'h55;
    settle();
    check("sim_dm_gnt", 64'({if_gnt, dm_gnt}), 64'(2'b01));
    advance();
    if_req = 0; dm_req = 0;
    settle();
    check("sim_mem_we", 64'(mem_we), 64'(4'hF));
    advance();
    settle();
    check("sim_rvalid", 64'({if_rvalid, dm_rvalid}), 64'(2'b01));
    advance();

    // Starvation guard: both held high with a fast memory.
    do_reset();
    grant_log.delete();
    if_req = 1; dm_req = 1; dm_we = 4'h3; mem_gnt = 1; mem_rvalid = 1;
    for (int i = 0; i < 30; i++) begin
      if_addr = $urandom; dm_addr = $urandom; dm_wdata = $urandom; mem_rdata = $urandom;
      settle();
      advance();
    end
    order = '0;
    for (int i = 0; i < 10; i++) if (i < grant_log.size()) order[i] = grant_log[i];
    check("starve_cnt", 64'(grant_log.size() >= 10), 64'(1));
    check("starve_order", 64'(order), 64'(10'b10000_10000));

    // Slow memory: request held five cycles with stable address.
    do_reset();
    dm_req = 1; dm_addr = 32'hABC0; dm_we = 4'h1; dm_wdata = 32'h77;
    settle();
    advance();
    dm_req = 1; dm_addr = 32'h1234; if_req = 1;
    for (int i = 0; i < 5; i++) begin
      mem_gnt = (i == 4);
      settle();
      check("slow_hold", 64'({mem_req, busy, if_gnt, dm_gnt, mem_addr}), 64'({4'b1100, 32'hABC0}));
      advance();
    end
    mem_gnt = 0;
    for (int i = 0; i < 3; i++) begin
      mem_rvalid = (i == 2); mem_rdata = 32'h99;
      settle();
      advance();
    end
    idle_inputs();

    // Reset while waiting for the response; late rvalid must be dropped.
    do_reset();
    dm_req = 1; dm_addr = 32'h80; mem_gnt = 1;
    settle();
    advance();
    dm_req = 0;
    settle();
    advance();
    mem_gnt = 0; reset = 1;
    settle();
    advance();
    reset = 0; mem_rvalid = 1; mem_rdata = 32'hDEAD;
    settle();
    check("late_rv", 64'({if_rvalid, dm_rvalid, busy}), 64'(0));
    advance();
    idle_inputs();

    // Randomized traffic, including spurious memory handshakes and resets.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      reset      = ($urandom_range(0, 149) == 0);
      if_req     = ($urandom_range(0, 3) != 0);
      dm_req     = ($urandom_range(0, 3) != 0);
      if_addr    = $urandom;
      dm_addr    = $urandom;
      dm_we      = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      dm_wdata   = $urandom;
      mem_gnt    = $urandom_range(0, 1) == 1;
      mem_rvalid = $urandom_range(0, 1) == 1;
      mem_rdata  = $urandom;
      settle();
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
